// File: rtl/fft2_butterfly_probe_if.sv
// Butterfly sample/result bus plus capture control and readback.
// No backpressure anywhere: the master presents a pair whenever in_valid is high.
interface fft2_butterfly_probe_if #(
  parameter int DATA_WIDTH = 4,
  parameter int OUT_WIDTH  = 5,
  parameter int CAP_DEPTH  = 16
);
  localparam int AW = $clog2(CAP_DEPTH);

  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] real_in_0;
  logic signed [DATA_WIDTH-1:0] real_in_1;
  logic signed [DATA_WIDTH-1:0] imag_in_0;
  logic signed [DATA_WIDTH-1:0] imag_in_1;
  logic                         out_valid;
  logic signed [OUT_WIDTH-1:0]  real_sum;
  logic signed [OUT_WIDTH-1:0]  real_diff;
  logic signed [OUT_WIDTH-1:0]  imag_sum;
  logic signed [OUT_WIDTH-1:0]  imag_diff;
  logic                         cap_arm;
  logic                         cap_done;
  logic [AW-1:0]                cap_rd_addr;
  logic [4*OUT_WIDTH-1:0]       cap_rd_data;

  modport master (
    output in_valid, real_in_0, real_in_1, imag_in_0, imag_in_1, cap_arm, cap_rd_addr,
    input  out_valid, real_sum, real_diff, imag_sum, imag_diff, cap_done, cap_rd_data
  );

  modport slave (
    input  in_valid, real_in_0, real_in_1, imag_in_0, imag_in_1, cap_arm, cap_rd_addr,
    output out_valid, real_sum, real_diff, imag_sum, imag_diff, cap_done, cap_rd_data
  );
endinterface

// File: rtl/fft2_butterfly_probe.sv
// Radix-2 butterfly (X0=x0+x1, X1=x0-x1) with a capture buffer; 2-clock latency, one pair/clock.
// No backpressure: every valid pair is accepted and results are never stalled.
module fft2_butterfly_probe #(
  parameter int DATA_WIDTH = 4,
  parameter int OUT_WIDTH  = 5,
  parameter int CAP_DEPTH  = 16
) (
  input logic                   CLK,
  input logic                   reset,
  fft2_butterfly_probe_if.slave bus
);
  localparam int AW = $clog2(CAP_DEPTH);
  localparam int WW = 4 * OUT_WIDTH;

  generate
    if (OUT_WIDTH < DATA_WIDTH + 1) begin : g_width_check
      $error("OUT_WIDTH must be at least DATA_WIDTH+1");
    end
    if (CAP_DEPTH < 2 || (1 << AW) != CAP_DEPTH) begin : g_depth_check
      $error("CAP_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} cap_state_t;

  logic                         s1_vld;
  logic signed [DATA_WIDTH-1:0] s1_r0, s1_r1, s1_i0, s1_i1;
  logic signed [OUT_WIDTH-1:0]  r0_x, r1_x, i0_x, i1_x;
  logic                         out_vld;
  logic signed [OUT_WIDTH-1:0]  real_sum, real_diff, imag_sum, imag_diff;
  cap_state_t                   state;
  logic [AW-1:0]                wr_ptr;
  logic                         cap_done_q;
  logic [WW-1:0]                rd_q;
  logic [WW-1:0]                ram [CAP_DEPTH];
  logic                         cap_wr;
  logic [WW-1:0]                res_word;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      s1_vld <= 1'b0;
      s1_r0  <= '0;
      s1_r1  <= '0;
      s1_i0  <= '0;
      s1_i1  <= '0;
    end else begin
      s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        s1_r0 <= bus.real_in_0;
        s1_r1 <= bus.real_in_1;
        s1_i0 <= bus.imag_in_0;
        s1_i1 <= bus.imag_in_1;
      end
    end
  end

  assign r0_x = {{(OUT_WIDTH-DATA_WIDTH){s1_r0[DATA_WIDTH-1]}}, s1_r0};
  assign r1_x = {{(OUT_WIDTH-DATA_WIDTH){s1_r1[DATA_WIDTH-1]}}, s1_r1};
  assign i0_x = {{(OUT_WIDTH-DATA_WIDTH){s1_i0[DATA_WIDTH-1]}}, s1_i0};
  assign i1_x = {{(OUT_WIDTH-DATA_WIDTH){s1_i1[DATA_WIDTH-1]}}, s1_i1};

  // Results hold their last values across out_valid gaps.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      out_vld   <= 1'b0;
      real_sum  <= '0;
      real_diff <= '0;
      imag_sum  <= '0;
      imag_diff <= '0;
    end else begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        real_sum  <= r0_x + r1_x;
        real_diff <= r0_x - r1_x;
        imag_sum  <= i0_x + i1_x;
        imag_diff <= i0_x - i1_x;
      end
    end
  end

  assign res_word = {real_sum, real_diff, imag_sum, imag_diff};
  assign cap_wr   = reset && (state == CAPTURE) && out_vld;

  always_ff @(posedge CLK) begin
    if (cap_wr) ram[wr_ptr] <= res_word;
  end

  // An arm in IDLE/DONE only changes state, so a result present that cycle is skipped.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      cap_done_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      rd_q <= ram[bus.cap_rd_addr];
      case (state)
        IDLE, DONE: begin
          if (bus.cap_arm) begin
            state      <= CAPTURE;
            wr_ptr     <= '0;
            cap_done_q <= 1'b0;
          end
        end
        CAPTURE: begin
          if (out_vld) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == AW'(CAP_DEPTH - 1)) begin
              state      <= DONE;
              cap_done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid   = out_vld;
  assign bus.real_sum    = real_sum;
  assign bus.real_diff   = real_diff;
  assign bus.imag_sum    = imag_sum;
  assign bus.imag_diff   = imag_diff;
  assign bus.cap_done    = cap_done_q;
  assign bus.cap_rd_data = rd_q;
endmodule

// File: tb/tb_fft2_butterfly_probe.sv
// Directed bench for fft2_butterfly_probe: hand-computed butterfly vectors, streaming, capture and reset.
module tb_fft2_butterfly_probe;
  logic CLK;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  fft2_butterfly_probe_if #(.DATA_WIDTH(4), .OUT_WIDTH(5), .CAP_DEPTH(16)) bus ();

  fft2_butterfly_probe #(.DATA_WIDTH(4), .OUT_WIDTH(5), .CAP_DEPTH(16)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [19:0] word_of(input int r0, input int r1, input int i0, input int i1);
    logic [4:0] a, b, c, d;
    a = 5'(r0 + r1);
    b = 5'(r0 - r1);
    c = 5'(i0 + i1);
    d = 5'(i0 - i1);
    return {a, b, c, d};
  endfunction

  function automatic logic [19:0] ramp_word(input int i);
    return word_of(i - 4, 2*i - 8, 7 - i, -i);
  endfunction

  function automatic logic [19:0] cap_word(input int j);
    return word_of((j % 16) - 8, 7 - (j % 8), (j % 7) - 3, -(j % 5));
  endfunction

  task automatic drive(input logic v, input int r0, input int r1, input int i0, input int i1);
    bus.in_valid  = v;
    bus.real_in_0 = 4'(r0);
    bus.real_in_1 = 4'(r1);
    bus.imag_in_0 = 4'(i0);
    bus.imag_in_1 = 4'(i1);
  endtask

  task automatic drive_ramp(input logic v, input int i);
    drive(v, i - 4, 2*i - 8, 7 - i, -i);
  endtask

  task automatic drive_cap(input logic v, input int j);
    drive(v, (j % 16) - 8, 7 - (j % 8), (j % 7) - 3, -(j % 5));
  endtask

  function automatic logic [19:0] out_word();
    return {bus.real_sum, bus.real_diff, bus.imag_sum, bus.imag_diff};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    bus.cap_arm     = 1'b0;
    bus.cap_rd_addr = '0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (out_word() !== 20'h0) $display("FAIL reset_results: got %h want 00000", out_word());
    else n_pass++;
    n_checks++;
    if (bus.cap_done !== 1'b0) $display("FAIL reset_cap_done: got %b want 0", bus.cap_done);
    else n_pass++;
    n_checks++;
    if (bus.cap_rd_data !== 20'h0) $display("FAIL reset_rd_data: got %h want 00000", bus.cap_rd_data);
    else n_pass++;
    reset = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    drive(1'b1, 3, 1, 1, 2);
    @(negedge CLK);
    drive(1'b0, 0, 0, 0, 0);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (out_word() !== {5'd4, 5'd2, 5'd3, 5'h1F})
      $display("FAIL basic_word: got %h want %h", out_word(), {5'd4, 5'd2, 5'd3, 5'h1F});
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (out_word() !== {5'd4, 5'd2, 5'd3, 5'h1F})
      $display("FAIL basic_hold: got %h want %h", out_word(), {5'd4, 5'd2, 5'd3, 5'h1F});
    else n_pass++;
  endtask

  task automatic test_extremes();
    drive(1'b1, -8, -8, 7, -8);
    @(negedge CLK);
    drive(1'b0, 0, 0, 0, 0);
    @(negedge CLK);
    n_checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL extreme_valid: got %b want 1", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (out_word() !== {5'h10, 5'h00, 5'h1F, 5'h0F})
      $display("FAIL extreme_word: got %h want %h", out_word(), {5'h10, 5'h00, 5'h1F, 5'h0F});
    else n_pass++;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    for (int k = 0; k < 12; k++) begin
      exp_v = (k >= 2) && (k < 10);
      n_checks++;
      if (bus.out_valid !== exp_v) $display("FAIL b2b_valid[%0d]: got %b want %b", k, bus.out_valid, exp_v);
      else n_pass++;
      if (k >= 2) begin
        n_checks++;
        if (out_word() !== ramp_word(k < 10 ? k - 2 : 7))
          $display("FAIL b2b_word[%0d]: got %h want %h", k, out_word(), ramp_word(k < 10 ? k - 2 : 7));
        else n_pass++;
      end
      drive_ramp(k < 8, k < 8 ? k : 0);
      @(negedge CLK);
    end
  endtask

  task automatic test_capture();
    // Arm lands on the cycle pair 0 is on the outputs, so pairs 1..16 are captured.
    for (int t = 0; t < 23; t++) begin
      n_checks++;
      if (bus.cap_done !== (t >= 19)) $display("FAIL cap_done[%0d]: got %b want %b", t, bus.cap_done, t >= 19);
      else n_pass++;
      drive_cap(t < 20, t < 20 ? t : 0);
      bus.cap_arm = (t == 2) || (t == 8);
      @(negedge CLK);
    end
    for (int a = 0; a <= 16; a++) begin
      if (a > 0) begin
        n_checks++;
        if (bus.cap_rd_data !== cap_word(a))
          $display("FAIL cap_read[%0d]: got %h want %h", a - 1, bus.cap_rd_data, cap_word(a));
        else n_pass++;
      end
      bus.cap_rd_addr = 4'(a < 16 ? a : 0);
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t < 36; t++) begin
      if (t == 7) begin
        n_checks++;
        if (out_word() !== 20'h0) $display("FAIL mid_reset_results: got %h want 00000", out_word());
        else n_pass++;
        n_checks++;
        if (bus.cap_done !== 1'b0) $display("FAIL mid_reset_cap_done: got %b want 0", bus.cap_done);
        else n_pass++;
      end
      if (t >= 7 && t <= 12) begin
        n_checks++;
        if (bus.out_valid !== (t == 12)) $display("FAIL mid_valid[%0d]: got %b want %b", t, bus.out_valid, t == 12);
        else n_pass++;
      end
      if (t == 12) begin
        n_checks++;
        if (out_word() !== cap_word(3)) $display("FAIL mid_first_word: got %h want %h", out_word(), cap_word(3));
        else n_pass++;
      end
      if (t == 13 || t == 32 || t == 33) begin
        n_checks++;
        if (bus.cap_done !== (t == 33)) $display("FAIL mid_cap_done[%0d]: got %b want %b", t, bus.cap_done, t == 33);
        else n_pass++;
      end
      if (t == 34 || t == 35) begin
        n_checks++;
        if (bus.cap_rd_data !== cap_word(t == 34 ? 0 : 15))
          $display("FAIL mid_read[%0d]: got %h want %h", t, bus.cap_rd_data, cap_word(t == 34 ? 0 : 15));
        else n_pass++;
      end
      reset = (t == 6) ? 1'b0 : 1'b1;
      bus.cap_arm = (t == 0) || (t == 14);
      if (t <= 6)                drive_cap(1'b1, t);
      else if (t == 10)          drive_cap(1'b1, 3);
      else if (t >= 15 && t <= 30) drive_cap(1'b1, t - 15);
      else                       drive(1'b0, 0, 0, 0, 0);
      bus.cap_rd_addr = (t == 34) ? 4'd15 : 4'd0;
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_capture();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
